// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - fetch-side bus: redirect input, imem request/response, decode handoff
// IFETCH_MISALIGN_EN adds the misalign_exc signal.
interface ifetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] fetch_pc;
`ifdef IFETCH_MISALIGN_EN
  logic        misalign_exc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_pc, misalign_exc
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_pc, misalign_exc
  );
`else
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_pc
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_pc
  );
`endif
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - PC register and REQ/WAIT/HOLD instruction-fetch sequencer
// Optional misaligned-redirect trap under IFETCH_MISALIGN_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic           clk,
  input  logic           rst,
  ifetch_unit_if.master  bus
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic        redirect;
  logic        park;
  logic        req_valid;

`ifdef IFETCH_MISALIGN_EN
  logic exc;
  assign redirect         = bus.redirect_valid & ~exc;
  assign park             = redirect & (bus.redirect_pc[1:0] != 2'b00);
  assign bus.misalign_exc = exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       exc <= 1'b0;
    else if (park) exc <= 1'b1;
  end
`else
  logic exc;
  assign exc      = 1'b0;
  assign redirect = bus.redirect_valid;
  assign park     = 1'b0;
`endif

  always_comb begin
    req_valid = 1'b0;
    if (state == S_REQ && !rst && !exc)
      req_valid = ~bus.redirect_valid;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc;
  assign bus.fetch_pc       = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      state          <= S_REQ;
      drop           <= 1'b0;
      bus.inst_valid <= 1'b0;
      bus.inst       <= 32'h0;
      bus.inst_pc    <= 32'h0;
    end else if (park) begin
      // Misaligned target: keep the PC for inspection, stop fetching.
      pc             <= bus.redirect_pc;
      state          <= S_REQ;
      drop           <= 1'b0;
      bus.inst_valid <= 1'b0;
    end else if (redirect) begin
      pc <= bus.redirect_pc;
      case (state)
        S_WAIT: begin
          // A response in this cycle is the stale one; otherwise it is still coming.
          if (bus.imem_resp_valid) begin
            drop  <= 1'b0;
            state <= S_REQ;
          end else begin
            drop  <= 1'b1;
          end
        end
        S_HOLD: begin
          bus.inst_valid <= 1'b0;
          state          <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (req_valid && bus.imem_req_ready)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              bus.inst       <= bus.imem_resp_data;
              bus.inst_pc    <= pc;
              bus.inst_valid <= 1'b1;
              state          <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.inst_ready) begin
            bus.inst_valid <= 1'b0;
            pc             <= pc + 32'd4;
            state          <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end
endmodule
